// File: rtl/aes_round_ctrl.sv
// Top-level sequencer for the AES-128 encrypt datapath: key expansion window,
// expansion check with timeout, pre-add-key, cipher rounds and result hand-off.
module aes_round_ctrl #(
   parameter int NUM_ROUNDS  = 10,
   parameter int KEY_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       key_valid,
   input  logic       data_valid,
   input  logic       key_expand_done,
   input  logic       out_ready,
   output logic       key_ack,
   output logic       data_ack,
   output logic       chg_key,
   output logic [3:0] cur_round,
   output logic       pre_add_en,
   output logic       round_en,
   output logic       last_round,
   output logic       out_valid,
   output logic       key_ok,
   output logic       key_err,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      KEY_EXP,
      KEY_CHK,
      PRE_ADD,
      ROUNDS,
      DONE
   } state_t;

   localparam logic [4:0] LAST_RND = 5'(NUM_ROUNDS);
   localparam logic [4:0] LAST_CHK = 5'(KEY_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [4:0] cnt, cnt_nxt;
   logic       key_ok_nxt, key_err_nxt;

   // One shared counter: expansion cycles, check timeout, then round index.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= IDLE;
         cnt     <= '0;
         key_ok  <= 1'b0;
         key_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         key_ok  <= key_ok_nxt;
         key_err <= key_err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      key_ok_nxt  = key_ok;
      key_err_nxt = key_err;
      key_ack     = 1'b0;
      data_ack    = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (key_valid) begin
               key_ack     = 1'b1;
               key_ok_nxt  = 1'b0;
               key_err_nxt = 1'b0;
               state_nxt   = KEY_EXP;
            end else if (data_valid && key_ok) begin
               data_ack  = 1'b1;
               state_nxt = PRE_ADD;
            end
         end
         KEY_EXP: begin
            if (cnt == LAST_RND) begin
               cnt_nxt   = '0;
               state_nxt = KEY_CHK;
            end else begin
               cnt_nxt = cnt + 5'd1;
            end
         end
         KEY_CHK: begin
            cnt_nxt = cnt + 5'd1;
            if (key_expand_done) begin
               key_ok_nxt = 1'b1;
               cnt_nxt    = '0;
               state_nxt  = IDLE;
            end else if (cnt == LAST_CHK) begin
               key_err_nxt = 1'b1;
               cnt_nxt     = '0;
               state_nxt   = IDLE;
            end
         end
         PRE_ADD: begin
            cnt_nxt   = 5'd1;
            state_nxt = ROUNDS;
         end
         ROUNDS: begin
            if (cnt == LAST_RND) begin
               cnt_nxt   = '0;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + 5'd1;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath controls decode from state only, so they are glitch-free of inputs.
   assign chg_key    = (state == KEY_EXP);
   assign pre_add_en = (state == PRE_ADD);
   assign round_en   = (state == ROUNDS);
   assign cur_round  = (state == ROUNDS) ? cnt[3:0] : 4'd0;
   assign last_round = (state == ROUNDS) && (cnt == LAST_RND);
   assign out_valid  = (state == DONE);
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with NUM_ROUNDS=10 and KEY_TIMEOUT=16.
module tb_aes_round_ctrl;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       key_valid = 1'b0;
   logic       data_valid = 1'b0;
   logic       key_expand_done = 1'b0;
   logic       out_ready = 1'b0;
   logic       key_ack, data_ack, chg_key, pre_add_en, round_en, last_round;
   logic       out_valid, key_ok, key_err, busy;
   logic [3:0] cur_round;

   int tests_run = 0;
   int tests_failed = 0;
   int bad;

   aes_round_ctrl #(.NUM_ROUNDS(10), .KEY_TIMEOUT(16)) dut (
      .clk(clk), .n_rst(n_rst),
      .key_valid(key_valid), .data_valid(data_valid),
      .key_expand_done(key_expand_done), .out_ready(out_ready),
      .key_ack(key_ack), .data_ack(data_ack), .chg_key(chg_key),
      .cur_round(cur_round), .pre_add_en(pre_add_en), .round_en(round_en),
      .last_round(last_round), .out_valid(out_valid), .key_ok(key_ok),
      .key_err(key_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input int obs, input int exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int all_outs();
      return {key_ack, data_ack, chg_key, cur_round, pre_add_en, round_en,
              last_round, out_valid, key_ok, key_err, busy};
   endfunction

   // Runs a full key load: ack, 11 expansion cycles, done one cycle into KEY_CHK.
   task automatic load_key();
      key_valid = 1'b1;
      #1;
      check_output("key_ack", key_ack, 1);
      tick();
      key_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 11; i++) begin
         if (chg_key !== 1'b1) bad++;
         tick();
      end
      check_output("chg_key_11", bad, 0);
      check_output("chg_key_off", chg_key, 0);
      tick();
      key_expand_done = 1'b1;
      tick();
      key_expand_done = 1'b0;
      check_output("key_ok_set", key_ok, 1);
      check_output("idle_after_key", busy, 0);
   endtask

   initial begin
      // Reset state
      #12;
      check_output("reset_outs", all_outs(), 0);
      n_rst = 1'b1;
      tick();
      check_output("idle_outs", all_outs(), 0);

      // Data without key is never acked
      data_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (data_ack !== 1'b0 || busy !== 1'b0) bad++;
         tick();
      end
      check_output("no_ack_nokey", bad, 0);
      data_valid = 1'b0;

      load_key();

      // One block with out_ready held low for 3 cycles
      data_valid = 1'b1;
      #1;
      check_output("data_ack", data_ack, 1);
      tick();
      data_valid = 1'b0;
      check_output("pre_add_en", pre_add_en, 1);
      check_output("pre_add_round", cur_round, 0);
      tick();
      bad = 0;
      for (int r = 1; r <= 10; r++) begin
         if (round_en !== 1'b1 || cur_round !== 4'(r) || last_round !== (r == 10)) bad++;
         if (out_valid !== 1'b0) bad++;
         tick();
      end
      check_output("rounds_seq", bad, 0);
      check_output("out_valid_T12", out_valid, 1);
      check_output("round_en_off", round_en, 0);
      tick();
      tick();
      tick();
      check_output("out_valid_held", out_valid, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_output("done_to_idle", {out_valid, busy}, 0);

      // Key takes priority over data
      key_valid = 1'b1;
      data_valid = 1'b1;
      #1;
      check_output("prio_key_ack", key_ack, 1);
      check_output("prio_no_data_ack", data_ack, 0);
      tick();
      key_valid = 1'b0;
      check_output("key_ok_cleared", key_ok, 0);
      bad = 0;
      for (int i = 0; i < 11; i++) begin
         if (data_ack !== 1'b0) bad++;
         tick();
      end
      check_output("no_data_ack_busy", bad, 0);
      key_expand_done = 1'b1;
      tick();
      key_expand_done = 1'b0;
      check_output("data_ack_after_rekey", data_ack, 1);
      tick();
      data_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      check_output("block2_done", out_valid, 1);
      tick();
      out_ready = 1'b0;
      check_output("block2_idle", busy, 0);

      // Expansion timeout
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      for (int i = 0; i < 11; i++) tick();
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         if (key_err !== 1'b0 || busy !== 1'b1) bad++;
         tick();
      end
      check_output("chk_wait", bad, 0);
      check_output("chk_last_busy", busy, 1);
      tick();
      check_output("key_err_set", {key_err, key_ok, busy}, 4);
      data_valid = 1'b1;
      #1;
      check_output("no_ack_keyerr", data_ack, 0);
      data_valid = 1'b0;
      tick();
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check_output("key_err_cleared", key_err, 0);
      for (int i = 0; i < 11; i++) tick();
      key_expand_done = 1'b1;
      tick();
      key_expand_done = 1'b0;
      check_output("key_ok_again", key_ok, 1);

      // Reset mid-round
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check_output("round5", cur_round, 5);
      #2;
      n_rst = 1'b0;
      #1;
      check_output("reset_mid_outs", all_outs(), 0);
      tick();
      n_rst = 1'b1;
      tick();
      check_output("post_reset_idle", all_outs(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
